// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int IFU_INSTR_W    = 8;
  localparam int IFU_IMEM_DEPTH = 16;

  localparam logic [7:0] HALT_INSTR = 8'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FETCH   = 2'b01,
    PRESENT = 2'b10,
    HALT    = 2'b11
  } ifu_state_e;

endpackage

// File: rtl/ifu_imem.sv
// Instruction memory: one write port, registered read, contents not reset.
module ifu_imem #(
  parameter int INSTR_W = 8,
  parameter int DEPTH   = 16,
  parameter int AW      = 4
) (
  input  logic               clock_pulse,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clock_pulse) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Stored-program fetch stage: loads bytes from switches, presents them over valid/ready.
// Build option IFU_LOOP_EN: wrap to pc 0 at end of program instead of halting.
//
// state   | meaning
// IDLE    | program entry / clear; waits for run with a non-empty program
// FETCH   | synchronous read of mem[pc] in flight
// PRESENT | instr_out valid, waiting for instr_ready
// HALT    | stopped (halt opcode, end of program, run low or bad redirect)
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int INSTR_W    = IFU_INSTR_W,
  parameter int IMEM_DEPTH = IFU_IMEM_DEPTH,
  parameter int PC_W       = $clog2(IMEM_DEPTH)
) (
  input  logic               clock_pulse,
  input  logic               resetn,
  input  logic               load_en,
  input  logic               load_we,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic               load_clear,
  input  logic               run,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W:0]      prog_len,
  output logic               load_full,
  output logic               halted,
  output logic               fault,
  output logic [1:0]         state
);

  ifu_state_e         cur_state, nxt_state;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W:0]      len_q, len_d;
  logic               fault_q, fault_d;
  logic               mem_we, mem_re;
  logic [INSTR_W-1:0] mem_rdata;
  logic [PC_W:0]      pc_inc;
  logic               redirect_ok;
  logic               is_halt_instr;

  assign pc_inc        = {1'b0, pc_q} + (PC_W+1)'(1);
  assign redirect_ok   = {1'b0, redirect_pc} < len_q;
  assign load_full     = (len_q == (PC_W+1)'(IMEM_DEPTH));
  assign mem_we        = (cur_state == IDLE) && !load_clear && load_en && load_we && !load_full;
  assign mem_re        = (cur_state == FETCH);
  assign is_halt_instr = (mem_rdata == INSTR_W'(HALT_INSTR));

  ifu_imem #(
    .INSTR_W (INSTR_W),
    .DEPTH   (IMEM_DEPTH),
    .AW      (PC_W)
  ) u_imem (
    .clock_pulse (clock_pulse),
    .we          (mem_we),
    .waddr       (len_q[PC_W-1:0]),
    .wdata       (load_instr),
    .re          (mem_re),
    .raddr       (pc_q),
    .rdata       (mem_rdata)
  );

  always_comb begin
    nxt_state = cur_state;
    pc_d      = pc_q;
    len_d     = len_q;
    fault_d   = fault_q;
    case (cur_state)
      IDLE: begin
        if (load_clear) begin
          len_d = '0;
        end else begin
          if (mem_we) len_d = len_q + (PC_W+1)'(1);
          if (run && !load_en && (len_q != '0)) begin
            pc_d      = '0;
            nxt_state = FETCH;
          end
        end
      end
      FETCH, PRESENT: begin
        // redirect outranks the handshake; the presented word is dropped
        if (redirect) begin
          if (redirect_ok) begin
            pc_d      = redirect_pc;
            nxt_state = FETCH;
          end else begin
            fault_d   = 1'b1;
            nxt_state = HALT;
          end
        end else if (cur_state == FETCH) begin
          nxt_state = PRESENT;
        end else if (instr_ready) begin
          if (is_halt_instr || !run) begin
            nxt_state = HALT;
          end else if (pc_inc == len_q) begin
`ifdef IFU_LOOP_EN
            pc_d      = '0;
            nxt_state = FETCH;
`else
            nxt_state = HALT;
`endif
          end else begin
            pc_d      = pc_inc[PC_W-1:0];
            nxt_state = FETCH;
          end
        end
      end
      HALT: begin
        if (!run) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clock_pulse or negedge resetn) begin
    if (!resetn) begin
      cur_state <= IDLE;
      pc_q      <= '0;
      len_q     <= '0;
      fault_q   <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      pc_q      <= pc_d;
      len_q     <= len_d;
      fault_q   <= fault_d;
    end
  end

  assign instr_valid = (cur_state == PRESENT);
  assign instr_out   = instr_valid ? mem_rdata : '0;
  assign halted      = (cur_state == HALT);
  assign pc          = pc_q;
  assign prog_len    = len_q;
  assign fault       = fault_q;
  assign state       = cur_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected (pc, instr) pairs are queued at stimulus time.
module tb_instr_fetch_unit;

  logic       clock_pulse = 1'b0;
  logic       resetn      = 1'b0;
  logic       load_en     = 1'b0;
  logic       load_we     = 1'b0;
  logic [7:0] load_instr  = '0;
  logic       load_clear  = 1'b0;
  logic       run         = 1'b0;
  logic       instr_ready = 1'b0;
  logic       redirect    = 1'b0;
  logic [3:0] redirect_pc = '0;
  logic [7:0] instr_out;
  logic       instr_valid;
  logic [3:0] pc;
  logic [4:0] prog_len;
  logic       load_full;
  logic       halted;
  logic       fault;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] instr;
    logic [3:0] pc;
  } sb_t;
  sb_t sb[$];
  logic mon_en = 1'b1;

  instr_fetch_unit dut (
    .clock_pulse (clock_pulse),
    .resetn      (resetn),
    .load_en     (load_en),
    .load_we     (load_we),
    .load_instr  (load_instr),
    .load_clear  (load_clear),
    .run         (run),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .pc          (pc),
    .prog_len    (prog_len),
    .load_full   (load_full),
    .halted      (halted),
    .fault       (fault),
    .state       (state)
  );

  always #5 clock_pulse = ~clock_pulse;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_pulse);
    #1;
  endtask

  task automatic push(input logic [7:0] instr, input logic [3:0] p);
    sb_t e;
    e.instr = instr;
    e.pc    = p;
    sb.push_back(e);
  endtask

  task automatic load_byte(input logic [7:0] b);
    load_en    = 1'b1;
    load_we    = 1'b1;
    load_instr = b;
    tick();
    load_we    = 1'b0;
    load_en    = 1'b0;
  endtask

  task automatic clear_prog();
    load_clear = 1'b1;
    tick();
    load_clear = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    for (int i = 0; i < 100 && !halted; i++) tick();
    chk(tag, halted, 1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !instr_valid; i++) tick();
    chk(tag, instr_valid, 1);
  endtask

  task automatic stop_run();
    run = 1'b0;
    tick();
    tick();
  endtask

  // a handshake lands on the coming rising edge: compare against the scoreboard
  always @(negedge clock_pulse) begin
    if (mon_en && resetn && instr_valid && instr_ready && !redirect) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", {24'h0, instr_out}, 32'hFFFF_FFFF);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_instr", instr_out, e.instr);
        chk("sb_pc", pc, e.pc);
      end
    end
  end

  initial begin
    #2;
    chk("rst_state", state, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_len", prog_len, 0);
    chk("rst_out", instr_out, 0);
    chk("rst_flags", {halted, fault, load_full}, 0);
    tick();
    resetn = 1'b1;
    tick();

    // basic program ending on the halt opcode
    load_byte(8'h13);
    load_byte(8'h31);
    load_byte(8'h00);
    chk("t1_len", prog_len, 3);
    push(8'h13, 0);
    push(8'h31, 1);
    push(8'h00, 2);
    instr_ready = 1'b1;
    run         = 1'b1;
    wait_halt("t1_halt");
    chk("t1_pc", pc, 2);
    chk("t1_valid", instr_valid, 0);
    chk("t1_sb_empty", sb.size(), 0);
    stop_run();
    chk("t1_idle", state, 0);

    // fill memory, overflow write ignored, run to end of program
    clear_prog();
    chk("t2_cleared", prog_len, 0);
    load_byte(8'hA5);
    for (int i = 1; i < 15; i++) load_byte(8'h40 + 8'(i));
    chk("t2_not_full", load_full, 0);
    load_byte(8'h4F);
    chk("t2_full", load_full, 1);
    chk("t2_len16", prog_len, 16);
    load_byte(8'hEE);
    chk("t2_len_hold", prog_len, 16);
    push(8'hA5, 0);
    for (int i = 1; i < 16; i++) push(8'h40 + 8'(i), 4'(i));
    run = 1'b1;
    wait_halt("t2_halt");
    chk("t2_pc_end", pc, 15);
    chk("t2_sb_empty", sb.size(), 0);
    stop_run();

    // back-pressure: output frozen while instr_ready is low
    clear_prog();
    load_byte(8'h21);
    load_byte(8'h22);
    load_byte(8'h23);
    instr_ready = 1'b0;
    run         = 1'b1;
    wait_valid("t3_valid");
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_out", instr_out, 8'h21);
      chk("t3_hold_valid", instr_valid, 1);
      chk("t3_hold_pc", pc, 0);
      tick();
    end
    push(8'h21, 0);
    push(8'h22, 1);
    push(8'h23, 2);
    instr_ready = 1'b1;
    wait_halt("t3_halt");
    chk("t3_sb_empty", sb.size(), 0);
    stop_run();

    // redirect beats a same-cycle handshake
    clear_prog();
    for (int i = 0; i < 5; i++) load_byte(8'h51 + 8'(i));
    instr_ready = 1'b0;
    run         = 1'b1;
    wait_valid("t4_valid");
    chk("t4_first", instr_out, 8'h51);
    push(8'h54, 3);
    push(8'h55, 4);
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 4'd3;
    tick();
    redirect = 1'b0;
    chk("t4_drop_valid", instr_valid, 0);
    chk("t4_redir_pc", pc, 3);
    wait_halt("t4_halt");
    chk("t4_fault_clear", fault, 0);
    chk("t4_sb_empty", sb.size(), 0);
    stop_run();

    // out-of-range redirect faults
    instr_ready = 1'b0;
    run         = 1'b1;
    wait_valid("t4b_valid");
    redirect    = 1'b1;
    redirect_pc = 4'd7;
    tick();
    redirect = 1'b0;
    chk("t4b_fault", fault, 1);
    chk("t4b_halted", halted, 1);
    chk("t4b_valid", instr_valid, 0);
    stop_run();
    chk("t4b_fault_sticky", fault, 1);

    // reset while presenting
    run = 1'b1;
    wait_valid("t5_valid");
    @(negedge clock_pulse);
    resetn = 1'b0;
    #1;
    chk("t5_valid", instr_valid, 0);
    chk("t5_state", state, 0);
    chk("t5_len", prog_len, 0);
    chk("t5_fault", fault, 0);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_stay_idle", state, 0);
    run = 1'b0;
    tick();

`ifdef IFU_LOOP_EN
    clear_prog();
    load_byte(8'h31);
    load_byte(8'h13);
    for (int i = 0; i < 3; i++) begin
      push(8'h31, 0);
      push(8'h13, 1);
    end
    instr_ready = 1'b1;
    run         = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    chk("t6_sb_empty", sb.size(), 0);
    chk("t6_not_halted", halted, 0);
    mon_en = 1'b0;
    run    = 1'b0;
    wait_halt("t6_halt");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
